// File: rtl/sonar_ranger.sv
// sonar_ranger: two-channel HC-SR04 style trigger/echo timing core.
// Optional macro SONAR_CM_EN reports range_data in cm instead of us.
module sonar_ranger #(
    parameter int CLK_FREQUENCY = 60_000_000,
    parameter int TRIG_US       = 10,
    parameter int ECHO_WAIT_US  = 30000,
    parameter int MAX_ECHO_US   = 30000,
    parameter int HOLDOFF_US    = 20000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [1:0]  sonar_echo,
    output logic [1:0]  sonar_trig,
    output logic [15:0] range_data,
    output logic        range_sel,
    output logic        range_timeout,
    output logic        range_valid,
    output logic        busy
);

    localparam int CLK_PER_US = CLK_FREQUENCY / 1_000_000;
    localparam int PW = $clog2(CLK_PER_US);

    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_US - 1);
    localparam logic [15:0] TRIG_LAST = 16'(TRIG_US - 1);
    localparam logic [15:0] WAIT_L    = 16'(ECHO_WAIT_US);
    localparam logic [15:0] MAX_L     = 16'(MAX_ECHO_US);
    localparam logic [15:0] HOLD_L    = 16'(HOLDOFF_US);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        HOLDOFF
    } state_t;

    state_t        state_q;
    logic          sel_q;
    logic [PW-1:0] pre_q, pre_d;
    logic [15:0]   us_q, us_d;
    logic          tick;
    logic [1:0]    sync1_q, echo_s_q;
    logic          echo_cur;
    logic [1:0]    trig_q;
    logic [15:0]   data_q;
    logic          sel_out_q, timeout_q, valid_q, busy_q;
    logic [15:0]   meas_val, sat_val;

    assign echo_cur = echo_s_q[sel_q];

    // Microsecond prescaler and saturating us counter advance values
    always_comb begin
        tick  = (pre_q == PRE_LAST);
        pre_d = tick ? '0 : pre_q + 1'b1;
        us_d  = us_q;
        if (tick && us_q != 16'hFFFF) begin
            us_d = us_q + 16'd1;
        end
    end

    // Two-flop synchronizer on both raw echo pins
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q  <= '0;
            echo_s_q <= '0;
        end else begin
            sync1_q  <= sonar_echo;
            echo_s_q <= sync1_q;
        end
    end

`ifdef SONAR_CM_EN
    logic [5:0]  sub_q, sub_d;
    logic [15:0] cm_q, cm_d;

    // One cm per 58 us of echo; sits at zero outside MEASURE
    always_comb begin
        sub_d = sub_q;
        cm_d  = cm_q;
        if (tick) begin
            if (sub_q == 6'd57) begin
                sub_d = '0;
                cm_d  = cm_q + 16'd1;
            end else begin
                sub_d = sub_q + 6'd1;
            end
        end
    end

    // cm counter state; cleared whenever not measuring
    always_ff @(posedge clk) begin
        if (!reset || state_q != MEASURE) begin
            sub_q <= '0;
            cm_q  <= '0;
        end else begin
            sub_q <= sub_d;
            cm_q  <= cm_d;
        end
    end

    assign meas_val = cm_q;
    assign sat_val  = 16'(MAX_ECHO_US / 58);
`else
    assign meas_val = us_q;
    assign sat_val  = MAX_L;
`endif

    // Ranging FSM: counters restart on every state entry, outputs registered
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            pre_q     <= '0;
            us_q      <= '0;
            trig_q    <= '0;
            data_q    <= '0;
            sel_out_q <= 1'b0;
            timeout_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            us_q    <= us_d;
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q <= TRIG;
                        pre_q   <= '0;
                        us_q    <= '0;
                        trig_q  <= sel_q ? 2'b10 : 2'b01;
                        busy_q  <= 1'b1;
                    end
                end
                TRIG: begin
                    if (tick && us_q == TRIG_LAST) begin
                        state_q <= WAIT_RISE;
                        pre_q   <= '0;
                        us_q    <= '0;
                        trig_q  <= '0;
                    end
                end
                WAIT_RISE: begin
                    if (echo_cur) begin
                        state_q <= MEASURE;
                        pre_q   <= '0;
                        us_q    <= '0;
                    end else if (us_q == WAIT_L) begin
                        state_q   <= HOLDOFF;
                        pre_q     <= '0;
                        us_q      <= '0;
                        data_q    <= '0;
                        sel_out_q <= sel_q;
                        timeout_q <= 1'b1;
                        valid_q   <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (us_q == MAX_L) begin
                        state_q   <= HOLDOFF;
                        pre_q     <= '0;
                        us_q      <= '0;
                        data_q    <= sat_val;
                        sel_out_q <= sel_q;
                        timeout_q <= 1'b1;
                        valid_q   <= 1'b1;
                    end else if (!echo_cur) begin
                        state_q   <= HOLDOFF;
                        pre_q     <= '0;
                        us_q      <= '0;
                        data_q    <= meas_val;
                        sel_out_q <= sel_q;
                        timeout_q <= 1'b0;
                        valid_q   <= 1'b1;
                    end
                end
                HOLDOFF: begin
                    if (us_q == HOLD_L) begin
                        state_q <= IDLE;
                        pre_q   <= '0;
                        us_q    <= '0;
                        sel_q   <= ~sel_q;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    trig_q  <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sonar_trig    = trig_q;
    assign range_data    = data_q;
    assign range_sel     = sel_out_q;
    assign range_timeout = timeout_q;
    assign range_valid   = valid_q;
    assign busy          = busy_q;

endmodule
